// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO family.
// Variants import this package so the default sizing and the DEPTH derivation live in one place.
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_ADDR_W_DEF = 3;

  // DEPTH is always a power of two so that the pointers wrap naturally.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write port, asynchronous read port.
// The array has no reset, so its contents survive a FIFO reset.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered-read or first-word-fall-through output,
// programmable almost-full/almost-empty thresholds and overflow/underflow pulses.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int ADDR_W    = FIFO_ADDR_W_DEF,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = fifo_depth(ADDR_W) - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH    = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_ok, pop_ok;
  logic [DATA_W-1:0] rd_data;

  // Occupancy is the only source of the status flags; pointers carry no extra wrap bit.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A push at full rides on a same-cycle pop; a pop at empty never sees the incoming word.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = push & ~push_ok;
    underflow_d = pop & ~pop_ok;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_W-1:0] dout_q, dout_d;
      logic              dout_valid_q, dout_valid_d;

      always_comb begin
        dout_d       = dout_q;
        dout_valid_d = pop_ok;
        if (pop_ok) begin
          dout_d = rd_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          dout_q       <= dout_d;
          dout_valid_q <= dout_valid_d;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
    end else begin : g_fwft
      // Head word is presented directly; pop acknowledges it.
      assign dout       = rd_data;
      assign dout_valid = ~empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one registered-read instance and one FWFT instance,
// both DEPTH=8, DATA_W=8, default thresholds (almost_full at 7, almost_empty at 1).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       push0, pop0, push1, pop1;
  logic [7:0] din0, din1;
  logic [7:0] dout0, dout1;
  logic       dv0, dv1, empty0, empty1, full0, full1, ae0, ae1, af0, af1;
  logic [3:0] count0, count1;
  logic       ovf0, ovf1, unf0, unf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .push(push0), .din(din0), .pop(pop0),
    .dout(dout0), .dout_valid(dv0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .push(push1), .din(din1), .pop(pop1),
    .dout(dout1), .dout_valid(dv1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      push0 = 1'b1;
      din0  = base + 8'(i);
      step();
    end
    push0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push0 = 1'b0; pop0 = 1'b0; din0 = 8'h00;
    push1 = 1'b0; pop1 = 1'b0; din1 = 8'h00;
    step(); step();
    rst = 1'b0;
    checks++; if (count0 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count0); end
    checks++; if (empty0 !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty0); end
    checks++; if (full0 !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full0); end
    checks++; if (ae0 !== 1'b1) begin failures++; $display("FAIL reset_aempty got=%b exp=1", ae0); end
    checks++; if (af0 !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", af0); end
    checks++; if (dout0 !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout0); end
    checks++; if (dv0 !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", dv0); end
    checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", ovf0, unf0); end
    checks++; if (dv1 !== 1'b0 || empty1 !== 1'b1) begin failures++; $display("FAIL reset_fwft got dv=%b empty=%b exp dv=0 empty=1", dv1, empty1); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      push0 = 1'b1; din0 = 8'(i);
      step();
      checks++; if (count0 !== 4'(i)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count0, i); end
      checks++; if (af0 !== (i >= 7)) begin failures++; $display("FAIL fill_afull at=%0d got=%b exp=%b", i, af0, (i >= 7)); end
      checks++; if (full0 !== (i == 8)) begin failures++; $display("FAIL fill_full at=%0d got=%b exp=%b", i, full0, (i == 8)); end
      checks++; if (ae0 !== (i <= 1)) begin failures++; $display("FAIL fill_aempty at=%0d got=%b exp=%b", i, ae0, (i <= 1)); end
    end
    push0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      pop0 = 1'b1;
      step();
      checks++; if (dout0 !== 8'(i)) begin failures++; $display("FAIL drain_dout got=%h exp=%h", dout0, 8'(i)); end
      checks++; if (dv0 !== 1'b1) begin failures++; $display("FAIL drain_dv got=%b exp=1", dv0); end
      checks++; if (count0 !== 4'(8 - i)) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", count0, 8 - i); end
    end
    pop0 = 1'b0;
    step();
    checks++; if (dv0 !== 1'b0) begin failures++; $display("FAIL drain_dv_drop got=%b exp=0", dv0); end
    checks++; if (dout0 !== 8'h08) begin failures++; $display("FAIL drain_hold got=%h exp=08", dout0); end
    checks++; if (empty0 !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty0); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q [$];
    logic [7:0] exp;
    push_words(8, 8'h11);
    push0 = 1'b1; din0 = 8'hAA;
    step();
    push0 = 1'b0;
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", ovf0); end
    checks++; if (count0 !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count0); end
    step();
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf0); end
    push0 = 1'b1; pop0 = 1'b1; din0 = 8'h55;
    step();
    push0 = 1'b0; pop0 = 1'b0;
    checks++; if (count0 !== 4'd8) begin failures++; $display("FAIL fullpp_count got=%0d exp=8", count0); end
    checks++; if (dout0 !== 8'h11) begin failures++; $display("FAIL fullpp_dout got=%h exp=11", dout0); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got=%b exp=0", ovf0); end
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h12 + 8'(i));
    exp_q.push_back(8'h55);
    for (int i = 0; i < 8; i++) begin
      pop0 = 1'b1;
      step();
      exp = exp_q.pop_front();
      checks++; if (dout0 !== exp) begin failures++; $display("FAIL ovf_drain idx=%0d got=%h exp=%h", i, dout0, exp); end
    end
    pop0 = 1'b0;
    checks++; if (empty0 !== 1'b1) begin failures++; $display("FAIL ovf_drain_empty got=%b exp=1", empty0); end
  endtask

  task automatic test_underflow();
    pop0 = 1'b1;
    step();
    pop0 = 1'b0;
    checks++; if (unf0 !== 1'b1) begin failures++; $display("FAIL unf_pulse got=%b exp=1", unf0); end
    checks++; if (dout0 !== 8'h55) begin failures++; $display("FAIL unf_dout got=%h exp=55", dout0); end
    checks++; if (dv0 !== 1'b0 || count0 !== 4'd0) begin failures++; $display("FAIL unf_state got dv=%b cnt=%0d exp dv=0 cnt=0", dv0, count0); end
    step();
    checks++; if (unf0 !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", unf0); end
    push0 = 1'b1; pop0 = 1'b1; din0 = 8'h77;
    step();
    push0 = 1'b0; pop0 = 1'b0;
    checks++; if (count0 !== 4'd1) begin failures++; $display("FAIL emptypp_count got=%0d exp=1", count0); end
    checks++; if (unf0 !== 1'b1) begin failures++; $display("FAIL emptypp_unf got=%b exp=1", unf0); end
    checks++; if (dout0 !== 8'h55 || dv0 !== 1'b0) begin failures++; $display("FAIL emptypp_dout got=%h dv=%b exp=55 dv=0", dout0, dv0); end
    pop0 = 1'b1;
    step();
    pop0 = 1'b0;
    checks++; if (dout0 !== 8'h77 || count0 !== 4'd0) begin failures++; $display("FAIL emptypp_read got=%h cnt=%0d exp=77 cnt=0", dout0, count0); end
  endtask

  task automatic test_fwft();
    push1 = 1'b1; din1 = 8'h3C;
    step();
    push1 = 1'b0;
    checks++; if (dout1 !== 8'h3C) begin failures++; $display("FAIL fwft_dout got=%h exp=3c", dout1); end
    checks++; if (dv1 !== 1'b1 || empty1 !== 1'b0) begin failures++; $display("FAIL fwft_dv got dv=%b empty=%b exp dv=1 empty=0", dv1, empty1); end
    pop1 = 1'b1;
    step();
    pop1 = 1'b0;
    checks++; if (empty1 !== 1'b1 || dv1 !== 1'b0) begin failures++; $display("FAIL fwft_pop got empty=%b dv=%b exp empty=1 dv=0", empty1, dv1); end
    push1 = 1'b1; din1 = 8'hA1;
    step();
    din1 = 8'hA2;
    step();
    push1 = 1'b0;
    checks++; if (dout1 !== 8'hA1 || count1 !== 4'd2) begin failures++; $display("FAIL fwft_head got=%h cnt=%0d exp=a1 cnt=2", dout1, count1); end
    pop1 = 1'b1;
    step();
    pop1 = 1'b0;
    checks++; if (dout1 !== 8'hA2 || dv1 !== 1'b1) begin failures++; $display("FAIL fwft_next got=%h dv=%b exp=a2 dv=1", dout1, dv1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] model_q [$];
    logic [7:0] exp;
    logic       pop_now;
    for (int i = 0; i < 32; i++) begin
      pop_now = (i >= 2) && (i % 5 != 4);
      push0 = 1'b1; din0 = 8'h40 + 8'(i); pop0 = pop_now;
      step();
      if (pop_now) begin
        exp = model_q.pop_front();
        checks++; if (dout0 !== exp) begin failures++; $display("FAIL wrap_dout cyc=%0d got=%h exp=%h", i, dout0, exp); end
      end
      model_q.push_back(8'h40 + 8'(i));
      checks++; if (count0 !== 4'(model_q.size()) || ovf0 !== 1'b0) begin failures++; $display("FAIL wrap_count cyc=%0d got=%0d ovf=%b exp=%0d ovf=0", i, count0, ovf0, model_q.size()); end
    end
    push0 = 1'b0;
    while (model_q.size() > 0) begin
      pop0 = 1'b1;
      step();
      exp = model_q.pop_front();
      checks++; if (dout0 !== exp) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", dout0, exp); end
    end
    pop0 = 1'b0;
    push_words(5, 8'hC0);
    checks++; if (count0 !== 4'd5) begin failures++; $display("FAIL prerst_count got=%0d exp=5", count0); end
    rst = 1'b1; push0 = 1'b1; pop0 = 1'b1; din0 = 8'hEE;
    step();
    rst = 1'b0; push0 = 1'b0; pop0 = 1'b0;
    checks++; if (count0 !== 4'd0 || empty0 !== 1'b1) begin failures++; $display("FAIL rst_mid got cnt=%0d empty=%b exp cnt=0 empty=1", count0, empty0); end
    checks++; if (dout0 !== 8'h00 || dv0 !== 1'b0) begin failures++; $display("FAIL rst_mid_dout got=%h dv=%b exp=00 dv=0", dout0, dv0); end
    checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin failures++; $display("FAIL rst_mid_err got=%b%b exp=00", ovf0, unf0); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_fwft();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
